// File: rtl/crc16_frame_ctrl.sv
// rtl/crc16_frame_ctrl.sv - CRC-16/X.25 byte framing controller: appends FCS (mode 0) or checks residue (mode 1)
module crc16_frame_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, FCS_LO, FCS_HI} stateT;

  localparam logic [15:0]      CRC_INIT = 16'hFFFF;
  localparam logic [15:0]      RESIDUE  = 16'hF0B8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Reflected CRC-16 (poly 0x1021 bit-reversed to 0x8408), one byte LSB first.
  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  stateT       state;
  logic [15:0] crc;
  logic [15:0] crcNext;
  logic        modeReg;
  logic        frameMode;
  logic        outFree;
  logic        outTaken;
  logic        accept;

  assign outFree   = !out_valid || out_ready;
  assign outTaken  = out_valid && out_ready;
  assign in_ready  = !rst && (state == IDLE || state == DATA) && outFree;
  assign accept    = in_valid && in_ready;
  assign crcNext   = crcByte(crc, in_data);
  // Mode is taken live on a frame's first byte, then held for the rest of the frame.
  assign frameMode = (state == IDLE) ? mode : modeReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= CRC_INIT;
      modeReg   <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;

      if (outTaken) begin
        out_valid <= 1'b0;
      end
      if (outTaken && out_last) begin
        busy <= 1'b0;
        if (frame_cnt != CNT_MAX) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      case (state)
        IDLE, DATA: begin
          if (accept) begin
            busy      <= 1'b1;
            crc       <= crcNext;
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= in_last && frameMode;
            if (state == IDLE) begin
              modeReg <= mode;
            end
            if (!in_last) begin
              state <= DATA;
            end else if (!frameMode) begin
              state <= FCS_LO;
            end else begin
              state   <= IDLE;
              crc     <= CRC_INIT;
              crc_ok  <= (crcNext == RESIDUE);
              crc_err <= (crcNext != RESIDUE);
              if (crcNext != RESIDUE && err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
              end
            end
          end
        end
        FCS_LO: begin
          if (outFree) begin
            out_data  <= ~crc[7:0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= FCS_HI;
          end
        end
        FCS_HI: begin
          if (outFree) begin
            out_data  <= ~crc[15:8];
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            state     <= IDLE;
            crc       <= CRC_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc16_frame_ctrl.md
# crc16_frame_ctrl

Byte-stream framing controller around the CRC-16/X.25 byte engine. In transmit mode it passes frame bytes through and appends the 2-byte FCS. In check mode it passes bytes through, including the received FCS, and flags good or bad frames. It sits between the byte-level bus capture logic and the comparator core, and sequences the CRC datapath per frame: init, per-byte enable, finalisation and residue check.

## Interface
- CNT_W, 16, width of the frame and error counters (saturating)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- mode  in  1  0 = generate/append FCS, 1 = check FCS; sampled on the first accepted byte of each frame
- in_data  in  8  frame byte
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final byte of the frame; in check mode this is the 2nd FCS byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  8  output byte
- out_valid  out  1  out_data valid
- out_last  out  1  final byte of the output frame
- out_ready  in  1  downstream accept
- crc_ok  out  1  one-cycle pulse: check-mode frame residue correct
- crc_err  out  1  one-cycle pulse: check-mode frame residue wrong
- busy  out  1  high from first accepted byte until the frame's last output byte is accepted
- frame_cnt  out  CNT_W  frames completed (both modes)
- err_cnt  out  CNT_W  check-mode frames with crc_err

## Operation
- CRC: poly x^16+x^12+x^5+1, reflected input and register, init 0xFFFF, FCS = ~crc, sent low byte first.
- Check: the reflected register after data+FCS equals 0xF0B8 (good residue).
- State machine states: IDLE, DATA, FCS_LO, FCS_HI.
- IDLE:
  - crc = 0xFFFF.
  - First accepted byte latches mode, updates the CRC and moves to DATA.
  - A 1-byte frame (in_last on the first byte) behaves as DATA with last.
- DATA:
  - Every accepted byte updates the CRC and is loaded into the output register.
  - In_last in mode 0: the byte is output with out_last = 0; next state FCS_LO.
  - In_last in mode 1: the byte is output with out_last = 1; crc_ok or crc_err is evaluated on the updated CRC; return to IDLE.
- FCS_LO: in_ready = 0; load ~crc[7:0]; next state FCS_HI.
- FCS_HI: in_ready = 0; load ~crc[15:8] with out_last = 1; return to IDLE.
- Output register:
  - Single stage; in_ready = (state is IDLE or DATA) && (!out_valid || out_ready).
  - FCS bytes load under the same !out_valid || out_ready condition.
- Counters:
  - frame_cnt increments when the out_last byte is accepted downstream.
  - err_cnt increments with crc_err.
  - Both saturate at all-ones.
- Mode changes mid-frame are ignored until the next IDLE.

## Timing
- Reset values:
  - out_data = 0x00, out_valid = 0, out_last = 0, in_ready = 0 during rst.
  - crc_ok = 0, crc_err = 0, busy = 0, counters = 0, crc = 0xFFFF, state IDLE.
- in_ready rises the first cycle after rst deasserts.
- Latency: an input byte appears on out_data the cycle after acceptance. FCS_LO is presented the cycle after the last data byte is accepted downstream.
- Full throughput: 1 byte/cycle with out_ready held high. Mode 0 adds exactly 2 cycles per frame.
- The first byte of the next frame may be accepted in the same cycle the FCS_HI byte is accepted downstream.
- crc_ok / crc_err pulse for exactly one cycle, the cycle after the in_last byte is accepted. They are mutually exclusive and never asserted in mode 0.
- Backpressure: out_data, out_last and out_valid stay stable while out_valid && !out_ready.
- Reset mid-frame: the frame is discarded. No pulses and no counter updates. Any partially sent FCS is abandoned.
- The CRC update is combinational over one byte; the register is written only on acceptance, never on stall cycles.

## Test plan
- Mode 0, ASCII "123456789", out_ready = 1:
  - Output is 31..39 then 0x6E, 0x90; out_last only on 0x90.
  - frame_cnt = 1; 11 cycles from first acceptance to the last output.
- Mode 1, "123456789",0x6E,0x90 with in_last on 0x90:
  - crc_ok pulses 1 cycle; err_cnt = 0.
  - Repeat with 0x91 as the last byte: crc_err pulses and err_cnt = 1.
- Backpressure:
  - Mode 0 frame 0x01 (1 byte), out_ready toggling 1/0 randomly.
  - Output is 0x01, then ~crc low and high bytes matching the reference model; data stays stable while stalled; in_ready low in FCS states.
- Back-to-back:
  - Two mode-0 frames "A" and "BC" streamed continuously.
  - No idle bubble beyond the 2 FCS cycles; second frame CRC starts from 0xFFFF; frame_cnt = 2.
- Reset mid-frame:
  - Assert rst after the 4th byte of "123456789".
  - Outputs return to reset values next cycle; counters 0.
  - A following "123456789" frame yields 0x6E, 0x90.
- Saturation: force CNT_W = 2 and run 5 bad check frames; err_cnt = 3, frame_cnt = 3.
